muap_lane_sequencer: RTL and testbench
======================================

Name: muap_lane_sequencer

Overview:
- Controller that serializes one combined MUA beat into per-channel 32-bit words. A beat carries LANES lanes of data, channel ID and channel hash.
- Data, channel and hash are sequenced from a single lane counter, so they cannot drift apart under backpressure.
- Tracks the frame number and stalls on fifo_mua_full.
- Sits between the MUA combiner output and the MUA FIFO write port.

Parameters:
- LANES, 5, lanes per combined beat
- DATA_W, 32, bits per lane of data and of hash
- CH_W, 12, bits per lane channel ID
- NUM_CH, 160, channels per frame; the last channel ID is NUM_CH-1
- FRAME_W, 32, frame counter width
- CH_NULL, 12'hFFF, channel ID that marks an empty lane

Ports:
- bus_clk  in  1  clock
- xike_reset  in  1  asynchronous active-high reset
- frame_count_rst  in  1  synchronous clear of the frame counter
- muap_comb_valid  in  1  input beat valid
- muap_comb_ready  out  1  input beat accepted when valid&&ready
- muap_comb_ch  in  LANES*CH_W (60)  lane channel IDs; lane i = [i*CH_W +: CH_W]
- muap_comb_data  in  LANES*DATA_W (160)  lane data
- muap_comb_ch_hash  in  LANES*DATA_W (160)  lane channel hash
- fifo_mua_full  in  1  downstream full; the output word is accepted when muap_valid && !fifo_mua_full
- muap_valid  out  1  output word valid
- muap_ch  out  CH_W  channel of the output word
- muap_data  out  DATA_W  data of the output word
- muap_ch_hash  out  DATA_W  hash of the output word
- muap_frame_No  out  FRAME_W  frame number of the output word
- overrun_err  out  1  sticky: input valid was dropped while not ready

Behaviour:
- Reset (xike_reset high, asynchronous): state IDLE, muap_comb_ready=1, muap_valid=0, and muap_ch/muap_data/muap_ch_hash/muap_frame_No=0. Internal frame counter=0, overrun_err=0.
- Reset mid-beat: the remaining lanes are discarded and no partial output follows.
- Holding registers: on input accept, all three vectors are latched together, along with a lane-valid mask (lane valid iff ch != CH_NULL).
- State IDLE: ready=1.
  - Accept with a non-empty mask: go to SHIFT, with the current lane = lowest valid lane.
  - Accept with an all-empty mask: the beat is consumed, no output, stay IDLE.
- State SHIFT: muap_valid=1. Outputs present the current lane's ch/data/hash and the current frame counter.
  - Outputs hold stable while fifo_mua_full=1.
  - On output accept: the lane bit is cleared and the next valid lane is chosen by lowest-index priority encode. Skipped lanes cost zero cycles.
  - When the accepted lane is the last valid lane: ready=1 that same cycle (combinational from !fifo_mua_full and state).
    - A new beat accepted that cycle (non-empty mask) gives back-to-back output with no bubble.
    - Otherwise, go to IDLE.
- Latency: input accept -> muap_valid on the next cycle. Sustained throughput is one word per cycle.
- Lane order: always lane 0 first (LSBs), ascending.
- Frame counter:
  - Increments by 1 when an output word with muap_ch == NUM_CH-1 is accepted.
  - Wraps modulo 2^FRAME_W.
  - muap_frame_No is the counter value sampled with the word, before that increment.
  - frame_count_rst clears it to 0 and wins over a simultaneous increment. The word accepted that cycle still carries the old value.
- overrun_err: set when muap_comb_valid=1 and ready=0. Cleared only by xike_reset.
- Channel IDs >= NUM_CH other than CH_NULL pass through unchanged and never increment the frame counter.

Decomposition:
- Package xike_muap_pkg holds LANES, DATA_W, CH_W, NUM_CH, CH_NULL, the state enum {IDLE, SHIFT}, and a lane-slice function.
- One sub-module: muap_lane_prienc, a LANES-bit lowest-set-bit encoder returning index and an any-set flag. It is used for both the initial and the next lane selection.

Test Plan:
- Single beat with ch = {4,3,2,1,0}, data lane i = 32'hA0+i, and fifo never full -> 5 words on consecutive cycles. Order ch 0..4, data A0..A4, hash matches its lane, frame_No=0 for all.
- Same beat with fifo_mua_full asserted for 3 cycles at the 2nd word -> word ch=1 held stable 3 cycles. No lane lost or duplicated, and data and hash stay aligned.
- Beat with lanes 1 and 3 = 12'hFFF -> exactly 3 words (ch of lanes 0,2,4) in 3 cycles. An all-CH_NULL beat -> 0 words, ready remains 1.
- Stream of 32 beats covering ch 0..159, then ch 0 -> words ch 0..159 carry frame_No=0 and the next ch 0 word carries frame_No=1. Ready is asserted on each 5th output accept, with no bubble between beats.
- frame_count_rst pulsed in the cycle a ch=159 word is accepted -> that word carries the old frame, and the following word carries frame_No=0.
- Hold muap_comb_valid while in SHIFT with ready=0 -> overrun_err=1 and stays set.
- Assert xike_reset during lane 2 -> muap_valid=0 immediately and ready=1 after release, with no residual lanes emitted.

Source files
------------

// File: rtl/xike_muap_pkg.sv
// xike_muap_pkg: shared constants, FSM states and lane-slice helpers for the MUA lane sequencer
package xike_muap_pkg;
  localparam int LANES = 5;
  localparam int DATA_W = 32;
  localparam int CH_W = 12;
  localparam int NUM_CH = 160;
  localparam int FRAME_W = 32;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [CH_W-1:0] CH_NULL = 12'hFFF;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  function automatic logic [DATA_W-1:0] lane_data(input logic [LANES*DATA_W-1:0] v, input logic [LANE_W-1:0] i);
    return v[i*DATA_W +: DATA_W];
  endfunction
  function automatic logic [CH_W-1:0] lane_ch(input logic [LANES*CH_W-1:0] v, input logic [LANE_W-1:0] i);
    return v[i*CH_W +: CH_W];
  endfunction
endpackage

// File: rtl/muap_lane_prienc.sv
// muap_lane_prienc: lowest-set-bit encoder over the lane mask
module muap_lane_prienc import xike_muap_pkg::*; (
  input  logic [LANES-1:0]  req,
  output logic [LANE_W-1:0] idx,
  output logic              any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = LANES - 1; i >= 0; i--) idx = req[i] ? LANE_W'(i) : idx;
  end
endmodule

// File: rtl/muap_lane_sequencer.sv
// muap_lane_sequencer: serializes a combined MUA beat into per-channel words
// and tracks the frame number from the last-channel word.
module muap_lane_sequencer import xike_muap_pkg::*; (
  input  logic                    bus_clk,
  input  logic                    xike_reset,
  input  logic                    frame_count_rst,
  input  logic                    muap_comb_valid,
  output logic                    muap_comb_ready,
  input  logic [LANES*CH_W-1:0]   muap_comb_ch,
  input  logic [LANES*DATA_W-1:0] muap_comb_data,
  input  logic [LANES*DATA_W-1:0] muap_comb_ch_hash,
  input  logic                    fifo_mua_full,
  output logic                    muap_valid,
  output logic [CH_W-1:0]         muap_ch,
  output logic [DATA_W-1:0]       muap_data,
  output logic [DATA_W-1:0]       muap_ch_hash,
  output logic [FRAME_W-1:0]      muap_frame_No,
  output logic                    overrun_err
);
  logic [0:0] state;
  logic [LANES-1:0] mask, in_mask, rem_mask;
  logic [LANE_W-1:0] cur, in_idx, rem_idx;
  logic in_any, rem_any, acc_out, in_acc;
  logic [LANES*CH_W-1:0] ch_r;
  logic [LANES*DATA_W-1:0] data_r, hash_r;
  logic [FRAME_W-1:0] frame_cnt;
  always_comb begin
    in_mask = '0;
    for (int i = 0; i < LANES; i++) in_mask[i] = lane_ch(muap_comb_ch, LANE_W'(i)) != CH_NULL;
  end
  // one lane pointer drives ch, data and hash so they stay aligned
  assign rem_mask = mask & ~(LANES'(1) << cur);
  assign muap_valid = state == SHIFT;
  assign acc_out = muap_valid && !fifo_mua_full;
  assign muap_comb_ready = (state == IDLE) || (acc_out && !rem_any);
  assign in_acc = muap_comb_valid && muap_comb_ready;
  assign muap_ch = lane_ch(ch_r, cur);
  assign muap_data = lane_data(data_r, cur);
  assign muap_ch_hash = lane_data(hash_r, cur);
  assign muap_frame_No = frame_cnt;
  muap_lane_prienc u_in_enc (.req(in_mask), .idx(in_idx), .any(in_any));
  muap_lane_prienc u_rem_enc (.req(rem_mask), .idx(rem_idx), .any(rem_any));
  always_ff @(posedge bus_clk or posedge xike_reset) begin
    if (xike_reset) begin
      state <= IDLE;
      mask <= '0;
      cur <= '0;
      ch_r <= '0;
      data_r <= '0;
      hash_r <= '0;
      frame_cnt <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (in_acc) begin
        ch_r <= muap_comb_ch;
        data_r <= muap_comb_data;
        hash_r <= muap_comb_ch_hash;
        mask <= in_mask;
        cur <= in_idx;
        state <= in_any ? SHIFT : IDLE;
      end else if (acc_out) begin
        mask <= rem_mask;
        cur <= rem_idx;
        state <= rem_any ? SHIFT : IDLE;
      end
      if (frame_count_rst) frame_cnt <= '0;
      else if (acc_out && muap_ch == CH_W'(NUM_CH - 1)) frame_cnt <= frame_cnt + 1'b1;
      if (muap_comb_valid && !muap_comb_ready) overrun_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_muap_lane_sequencer.sv
// tb_muap_lane_sequencer: table-driven vectors plus directed multi-cycle sequences
module tb_muap_lane_sequencer;
  logic bus_clk = 1'b0, xike_reset, frame_count_rst, muap_comb_valid, fifo_mua_full;
  logic [59:0] muap_comb_ch;
  logic [159:0] muap_comb_data, muap_comb_ch_hash;
  logic muap_comb_ready, muap_valid, overrun_err;
  logic [11:0] muap_ch;
  logic [31:0] muap_data, muap_ch_hash, muap_frame_No;
  int passed = 0, total = 0;

  muap_lane_sequencer dut (
    .bus_clk(bus_clk), .xike_reset(xike_reset), .frame_count_rst(frame_count_rst),
    .muap_comb_valid(muap_comb_valid), .muap_comb_ready(muap_comb_ready),
    .muap_comb_ch(muap_comb_ch), .muap_comb_data(muap_comb_data),
    .muap_comb_ch_hash(muap_comb_ch_hash), .fifo_mua_full(fifo_mua_full),
    .muap_valid(muap_valid), .muap_ch(muap_ch), .muap_data(muap_data),
    .muap_ch_hash(muap_ch_hash), .muap_frame_No(muap_frame_No), .overrun_err(overrun_err)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic vin;
    logic [59:0] ch;
    logic full;
    logic ev;
    logic er;
    logic [11:0] ech;
    logic [31:0] edata;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  function automatic logic [59:0] mk_ch(input int c0, input int c1, input int c2, input int c3, input int c4);
    return {12'(c4), 12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  function automatic logic [159:0] mk_dat(input logic [31:0] base);
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic vec_t v(input logic vin, input logic [59:0] ch, input logic full,
                             input logic ev, input logic er, input int ech, input int lane);
    vec_t r;
    r.vin = vin; r.ch = ch; r.full = full; r.ev = ev; r.er = er;
    r.ech = 12'(ech); r.edata = 32'hA0 + 32'(lane);
    return r;
  endfunction

  task automatic drive(input logic vin, input logic [59:0] ch, input logic [31:0] dbase, input logic [31:0] hbase);
    muap_comb_valid = vin;
    muap_comb_ch = ch;
    muap_comb_data = mk_dat(dbase);
    muap_comb_ch_hash = mk_dat(hbase);
  endtask

  initial begin
    logic [59:0] ch_a, ch_s, ch_n, ch_z;
    int b, w, cyc;
    ch_a = mk_ch(0, 1, 2, 3, 4);
    ch_s = mk_ch(10, 'hFFF, 12, 'hFFF, 14);
    ch_n = mk_ch('hFFF, 'hFFF, 'hFFF, 'hFFF, 'hFFF);
    ch_z = mk_ch(0, 'hFFF, 'hFFF, 'hFFF, 'hFFF);
    xike_reset = 1'b1; frame_count_rst = 1'b0; fifo_mua_full = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick(); tick();
    chk("rst valid", muap_valid, 0);
    chk("rst ready", muap_comb_ready, 1);
    chk("rst ch", muap_ch, 0);
    chk("rst data", muap_data, 0);
    chk("rst hash", muap_ch_hash, 0);
    chk("rst frame", muap_frame_No, 0);
    chk("rst overrun", overrun_err, 0);
    xike_reset = 1'b0;

    tbl.push_back(v(1, ch_a, 0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, ch_a, 0, 1, i == 4, i, i));
    tbl.push_back(v(0, ch_a, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, ch_a, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, ch_a, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, ch_a, 1, 1, 0, 1, 1));
    for (int i = 1; i < 5; i++) tbl.push_back(v(0, ch_a, 0, 1, i == 4, i, i));
    tbl.push_back(v(0, ch_a, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, ch_s, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, ch_s, 0, 1, 0, 10, 0));
    tbl.push_back(v(0, ch_s, 0, 1, 0, 12, 2));
    tbl.push_back(v(0, ch_s, 0, 1, 1, 14, 4));
    tbl.push_back(v(1, ch_n, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, ch_n, 0, 0, 1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vin, tbl[i].ch, 32'hA0, 32'hB0);
      fifo_mua_full = tbl[i].full;
      #1;
      chk($sformatf("v%0d valid", i), muap_valid, tbl[i].ev);
      chk($sformatf("v%0d ready", i), muap_comb_ready, tbl[i].er);
      chk($sformatf("v%0d overrun", i), overrun_err, 0);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d ch", i), muap_ch, tbl[i].ech);
        chk($sformatf("v%0d data", i), muap_data, tbl[i].edata);
        chk($sformatf("v%0d hash", i), muap_ch_hash, tbl[i].edata + 32'h10);
        chk($sformatf("v%0d frame", i), muap_frame_No, 0);
      end
      tick();
    end
    fifo_mua_full = 1'b0;

    // full frame of 32 beats then one ch 0 word, back to back
    b = 0; w = 0; cyc = 0;
    while (w < 161 && cyc < 400) begin
      if (b < 32) drive(1'b1, mk_ch(5*b, 5*b+1, 5*b+2, 5*b+3, 5*b+4), 32'h10000 + 32'(5*b), 32'h20000 + 32'(5*b));
      else drive(b == 32, ch_z, 32'h10000 + 32'd160, 32'h20000 + 32'd160);
      #1;
      if (muap_valid) begin
        chk($sformatf("s%0d ch", w), muap_ch, w == 160 ? 0 : w);
        chk($sformatf("s%0d data", w), muap_data, 32'h10000 + 32'(w));
        chk($sformatf("s%0d hash", w), muap_ch_hash, 32'h20000 + 32'(w));
        chk($sformatf("s%0d frame", w), muap_frame_No, w == 160 ? 1 : 0);
        chk($sformatf("s%0d ready", w), muap_comb_ready, (w % 5 == 4) || w == 160);
        w++;
      end else if (w > 0) chk($sformatf("s%0d bubble", w), muap_valid, 1);
      if (muap_comb_valid && muap_comb_ready) b++;
      tick();
      cyc++;
    end
    chk("stream words", 64'(w), 161);

    drive(1'b1, mk_ch(155, 156, 157, 158, 159), 32'h10000 + 32'd155, 32'h20000 + 32'd155);
    #1;
    chk("fr ready", muap_comb_ready, 1);
    tick();
    drive(1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fr%0d ch", k), muap_ch, 155 + k);
      chk($sformatf("fr%0d frame", k), muap_frame_No, 1);
      tick();
    end
    frame_count_rst = 1'b1;
    drive(1'b1, ch_z, 32'h50, 32'h60);
    #1;
    chk("fr159 ch", muap_ch, 159);
    chk("fr159 frame", muap_frame_No, 1);
    chk("fr159 ready", muap_comb_ready, 1);
    tick();
    frame_count_rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    #1;
    chk("frc valid", muap_valid, 1);
    chk("frc ch", muap_ch, 0);
    chk("frc data", muap_data, 32'h50);
    chk("frc frame", muap_frame_No, 0);
    tick();

    drive(1'b1, ch_a, 32'hA0, 32'hB0);
    tick();
    #1;
    chk("ov ready", muap_comb_ready, 0);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    chk("ov set", overrun_err, 1);
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("ov idle", muap_valid, 0);
    chk("ov sticky", overrun_err, 1);
    tick();

    drive(1'b1, ch_a, 32'hA0, 32'hB0);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    #1;
    chk("mr lane2", muap_ch, 2);
    xike_reset = 1'b1;
    #1;
    chk("mr valid", muap_valid, 0);
    chk("mr overrun", overrun_err, 0);
    chk("mr frame", muap_frame_No, 0);
    tick();
    xike_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("mr%0d valid", k), muap_valid, 0);
      chk($sformatf("mr%0d ready", k), muap_comb_ready, 1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
